t_vga_v1_cpu_v1_jtag_debug_host: RTL and testbench

- Synthesizable initiator for the CPU's virtual-JTAG debug channel.
- Takes one instruction plus one data word per command and sequences the virtual-JTAG strobes: update-IR, capture-DR, DR_WIDTH shift cycles, then update-DR.
- Returns the word shifted out of the debug module on tdo.
- Sits where the sld_virtual_jtag_basic PHY normally sits, for on-chip self-test and host-less debug of the Nios II core.

---
 rtl/t_vga_v1_cpu_v1_jtag_debug_host.sv | 135 +++++++++++++
 tb/tb_t_vga_v1_cpu_v1_jtag_debug_host.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/t_vga_v1_cpu_v1_jtag_debug_host.sv
// Virtual-JTAG debug initiator: loads one IR/DR command, walks UIR -> CDR -> SDR x DR_WIDTH -> UDR
// on a divided tck and returns the word shifted out of the debug module on tdo.
module t_vga_v1_cpu_v1_jtag_debug_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TCK_DIV - 1);
  localparam int BIT_W = $clog2(DR_WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR} state_t;

  state_t              state;
  logic [CNT_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DR_WIDTH-1:0] shift;
  logic [DR_WIDTH-1:0] capture;
  logic [IR_WIDTH-1:0] ir_pend;
  logic                armed;
  logic                div_end;
  logic                fall;
  logic                rise;

  assign div_end = (div_cnt == DIV_LAST);
  assign fall    = div_end & tck;
  assign rise    = div_end & ~tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (div_end) begin
      div_cnt <= '0;
      tck     <= ~tck;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // ir_in is staged through ir_pend so it only moves on a tck fall edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      armed          <= 1'b0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      shift          <= '0;
      capture        <= '0;
      bit_cnt        <= '0;
      ir_pend        <= '0;
      ir_in          <= '0;
      tdi            <= 1'b0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      jtag_state_rti <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        ir_pend   <= cmd_ir;
        shift     <= cmd_data;
        armed     <= 1'b1;
        cmd_ready <= 1'b0;
      end
      if (rise && state == SDR)
        capture <= {tdo, capture[DR_WIDTH-1:1]};
      if (fall) begin
        case (state)
          IDLE: if (armed) begin
            state          <= UIR;
            armed          <= 1'b0;
            ir_in          <= ir_pend;
            vs_uir         <= 1'b1;
            jtag_state_rti <= 1'b0;
          end
          UIR: begin
            state  <= CDR;
            vs_uir <= 1'b0;
            vs_cdr <= 1'b1;
          end
          CDR: begin
            state   <= SDR;
            vs_cdr  <= 1'b0;
            vs_sdr  <= 1'b1;
            tdi     <= shift[0];
            bit_cnt <= '0;
          end
          SDR: if (bit_cnt == BIT_LAST) begin
            state  <= UDR;
            vs_sdr <= 1'b0;
            vs_udr <= 1'b1;
            tdi    <= 1'b0;
          end else begin
            shift   <= shift >> 1;
            tdi     <= shift[1];
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
          UDR: begin
            state          <= IDLE;
            vs_udr         <= 1'b0;
            rsp_data       <= capture;
            rsp_valid      <= 1'b1;
            cmd_ready      <= 1'b1;
            jtag_state_rti <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t_vga_v1_cpu_v1_jtag_debug_host.sv
// Directed bench: DR_WIDTH=38/TCK_DIV=2 instance for the main sequence, DR_WIDTH=2/TCK_DIV=1 for the minimal case.
module tb_t_vga_v1_cpu_v1_jtag_debug_host;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_cmd_valid = 1'b0, a_cmd_ready;
  logic [1:0]  a_cmd_ir = '0;
  logic [37:0] a_cmd_data = '0;
  logic        a_rsp_valid;
  logic [37:0] a_rsp_data;
  logic        a_tck, a_tdi, a_tdo, a_vs_uir, a_vs_cdr, a_vs_sdr, a_vs_udr, a_rti;
  logic [1:0]  a_ir_in;
  logic        a_loop = 1'b1, a_tdo_fix = 1'b0;
  assign a_tdo = a_loop ? a_tdi : a_tdo_fix;

  logic        b_cmd_valid = 1'b0, b_cmd_ready;
  logic [1:0]  b_cmd_ir = '0;
  logic [1:0]  b_cmd_data = '0;
  logic        b_rsp_valid;
  logic [1:0]  b_rsp_data;
  logic        b_tck, b_tdi, b_tdo, b_vs_uir, b_vs_cdr, b_vs_sdr, b_vs_udr, b_rti;
  logic [1:0]  b_ir_in;
  assign b_tdo = b_tdi;

  t_vga_v1_cpu_v1_jtag_debug_host #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_ir(a_cmd_ir), .cmd_data(a_cmd_data), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
    .tck(a_tck), .tdi(a_tdi), .tdo(a_tdo), .ir_in(a_ir_in), .vs_uir(a_vs_uir), .vs_cdr(a_vs_cdr),
    .vs_sdr(a_vs_sdr), .vs_udr(a_vs_udr), .jtag_state_rti(a_rti));

  t_vga_v1_cpu_v1_jtag_debug_host #(.DR_WIDTH(2), .IR_WIDTH(2), .TCK_DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_ir(b_cmd_ir), .cmd_data(b_cmd_data), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .tck(b_tck), .tdi(b_tdi), .tdo(b_tdo), .ir_in(b_ir_in), .vs_uir(b_vs_uir), .vs_cdr(b_vs_cdr),
    .vs_sdr(b_vs_sdr), .vs_udr(b_vs_udr), .jtag_state_rti(b_rti));

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Follows one transaction on dut_a from the clk after acceptance until its rsp_valid clk.
  task automatic watch_a(input int budget, input logic nx_valid, input logic [1:0] nx_ir,
                         input logic [37:0] nx_data, output int t_uir, output int t_rsp,
                         output int sdr_n, output int tdi_hi, output int ready_hi, output int multi,
                         output logic [1:0] ir_uir, output logic uir_fall, output logic timeout);
    logic prev_tck;
    int strobes;
    t_uir = -1; t_rsp = -1; sdr_n = 0; tdi_hi = 0; ready_hi = 0; multi = 0;
    ir_uir = '0; uir_fall = 1'b0; timeout = 1'b1;
    prev_tck = a_tck;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a_cmd_valid = nx_valid;
        a_cmd_ir    = nx_ir;
        a_cmd_data  = nx_data;
      end
      strobes = int'(a_vs_uir) + int'(a_vs_cdr) + int'(a_vs_sdr) + int'(a_vs_udr);
      if ((a_rti && strobes != 0) || (!a_rti && strobes != 1)) multi++;
      if (a_vs_uir && t_uir < 0) begin
        t_uir = n;
        ir_uir = a_ir_in;
        uir_fall = prev_tck && !a_tck;
      end
      if (a_vs_sdr) begin
        sdr_n++;
        if (a_tdi) tdi_hi++;
      end
      if (a_rsp_valid) begin
        t_rsp = n;
        timeout = 1'b0;
        break;
      end
      if (a_cmd_ready) ready_hi++;
      prev_tck = a_tck;
    end
  endtask

  int t_uir, t_rsp, sdr_n, tdi_hi, ready_hi, multi;
  logic [1:0] ir_uir;
  logic uir_fall, timeout;
  int rises, first_rise, last_rise, bad_gap, idle_bad, rsp_seen, waited;
  int bu, bc, bs, bd, b_first, b_rsp;
  logic prev;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_tck", 64'(a_tck), 64'(0));
    check("rst_tdi_ir", 64'({a_tdi, a_ir_in}), 64'(0));
    check("rst_strobes", 64'({a_vs_uir, a_vs_cdr, a_vs_sdr, a_vs_udr}), 64'(0));
    check("rst_rti_ready", 64'({a_rti, a_cmd_ready}), 64'(2'b11));
    check("rst_rsp", 64'({a_rsp_valid, a_rsp_data}), 64'(0));
    reset_n = 1'b1;

    // Idle 20 clk: tck period 4, no strobes, ready
    rises = 0; first_rise = -1; last_rise = -1; bad_gap = 0; idle_bad = 0; prev = a_tck;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!prev && a_tck) begin
        if (last_rise >= 0 && n - last_rise != 4) bad_gap++;
        if (first_rise < 0) first_rise = n;
        last_rise = n;
        rises++;
      end
      if (a_vs_uir || a_vs_cdr || a_vs_sdr || a_vs_udr || !a_rti || !a_cmd_ready) idle_bad++;
      prev = a_tck;
    end
    check("idle_first_rise", 64'(first_rise), 64'(2));
    check("idle_rises", 64'(rises), 64'(5));
    check("idle_tck_gap", 64'(bad_gap), 64'(0));
    check("idle_quiet", 64'(idle_bad), 64'(0));

    // Loopback transaction
    a_loop = 1'b1; a_cmd_valid = 1'b1; a_cmd_ir = 2'b01; a_cmd_data = 38'h2A_5A5A_A5A5;
    watch_a(400, 1'b0, 2'b00, 38'h0, t_uir, t_rsp, sdr_n, tdi_hi, ready_hi, multi, ir_uir, uir_fall, timeout);
    check("lb_timeout", 64'(timeout), 64'(0));
    check("lb_ready_low", 64'(ready_hi), 64'(0));
    check("lb_ir_at_uir", 64'(ir_uir), 64'(2'b01));
    check("lb_uir_on_fall", 64'(uir_fall), 64'(1));
    check("lb_sdr_clks", 64'(sdr_n), 64'(152));
    check("lb_latency", 64'(t_rsp - t_uir), 64'(164));
    check("lb_onehot", 64'(multi), 64'(0));
    check("lb_rsp_data", 64'(a_rsp_data), 64'(38'h2A_5A5A_A5A5));
    check("lb_rsp_rdy_rti", 64'({a_cmd_ready, a_rti}), 64'(2'b11));
    @(negedge clk);
    check("lb_rsp_pulse", 64'(a_rsp_valid), 64'(0));
    repeat (5) @(negedge clk);
    check("lb_hold", 64'({a_ir_in, a_rsp_data}), 64'({2'b01, 38'h2A_5A5A_A5A5}));

    // tdo tied high, zero data
    a_loop = 1'b0; a_tdo_fix = 1'b1;
    a_cmd_valid = 1'b1; a_cmd_ir = 2'b11; a_cmd_data = 38'h0;
    watch_a(400, 1'b0, 2'b00, 38'h0, t_uir, t_rsp, sdr_n, tdi_hi, ready_hi, multi, ir_uir, uir_fall, timeout);
    check("one_timeout", 64'(timeout), 64'(0));
    check("one_rsp_data", 64'(a_rsp_data), 64'(38'h3F_FFFF_FFFF));
    check("one_tdi_low", 64'(tdi_hi), 64'(0));
    check("one_latency", 64'(t_rsp - t_uir), 64'(164));
    repeat (3) @(negedge clk);

    // Back-to-back with cmd_valid held high
    a_loop = 1'b1;
    a_cmd_valid = 1'b1; a_cmd_ir = 2'b11; a_cmd_data = 38'h00_DEAD_BEEF;
    watch_a(400, 1'b1, 2'b10, 38'h1, t_uir, t_rsp, sdr_n, tdi_hi, ready_hi, multi, ir_uir, uir_fall, timeout);
    check("b2b1_timeout", 64'(timeout), 64'(0));
    check("b2b1_rsp_data", 64'(a_rsp_data), 64'(38'h00_DEAD_BEEF));
    check("b2b1_ready_low", 64'(ready_hi), 64'(0));
    watch_a(400, 1'b0, 2'b00, 38'h0, t_uir, t_rsp, sdr_n, tdi_hi, ready_hi, multi, ir_uir, uir_fall, timeout);
    check("b2b2_timeout", 64'(timeout), 64'(0));
    check("b2b2_uir_start", 64'(t_uir), 64'(4));
    check("b2b2_uir_on_fall", 64'(uir_fall), 64'(1));
    check("b2b2_ir", 64'(ir_uir), 64'(2'b10));
    check("b2b2_ready_low", 64'(ready_hi), 64'(0));
    check("b2b2_rsp_data", 64'(a_rsp_data), 64'(38'h1));
    check("b2b2_onehot", 64'(multi), 64'(0));
    repeat (3) @(negedge clk);

    // Reset pulse during SDR bit 17
    a_cmd_valid = 1'b1; a_cmd_ir = 2'b01; a_cmd_data = 38'h3_0F0F_0F0F;
    @(negedge clk);
    a_cmd_valid = 1'b0;
    waited = 0;
    while (!a_vs_sdr && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    repeat (69) @(negedge clk);
    check("mid_in_sdr", 64'(a_vs_sdr), 64'(1));
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_strobes", 64'({a_vs_uir, a_vs_cdr, a_vs_sdr, a_vs_udr}), 64'(0));
    check("mid_tck", 64'(a_tck), 64'(0));
    check("mid_ready_rti", 64'({a_cmd_ready, a_rti, a_rsp_valid}), 64'(3'b110));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rsp_seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (a_rsp_valid) rsp_seen++;
    end
    check("mid_no_rsp", 64'(rsp_seen), 64'(0));
    a_cmd_valid = 1'b1; a_cmd_ir = 2'b11; a_cmd_data = 38'h15_1234_5678;
    watch_a(400, 1'b0, 2'b00, 38'h0, t_uir, t_rsp, sdr_n, tdi_hi, ready_hi, multi, ir_uir, uir_fall, timeout);
    check("post_timeout", 64'(timeout), 64'(0));
    check("post_rsp_data", 64'(a_rsp_data), 64'(38'h15_1234_5678));
    check("post_ir", 64'(ir_uir), 64'(2'b11));
    check("post_latency", 64'(t_rsp - t_uir), 64'(164));

    // Minimal DR_WIDTH=2, TCK_DIV=1 instance
    b_cmd_valid = 1'b1; b_cmd_ir = 2'b10; b_cmd_data = 2'b10;
    bu = 0; bc = 0; bs = 0; bd = 0; b_first = -1; b_rsp = -1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 1) b_cmd_valid = 1'b0;
      if (b_vs_uir) begin
        bu++;
        if (b_first < 0) b_first = n;
      end
      if (b_vs_cdr) bc++;
      if (b_vs_sdr) bs++;
      if (b_vs_udr) bd++;
      if (b_rsp_valid) begin
        b_rsp = n;
        break;
      end
    end
    check("min_uir_clks", 64'(bu), 64'(2));
    check("min_cdr_clks", 64'(bc), 64'(2));
    check("min_sdr_clks", 64'(bs), 64'(4));
    check("min_udr_clks", 64'(bd), 64'(2));
    check("min_latency", 64'(b_rsp - b_first), 64'(10));
    check("min_rsp_data", 64'({b_ir_in, b_rsp_data}), 64'({2'b10, 2'b10}));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vecs);
    $fatal(1, "watchdog");
  end

endmodule
